// File: rtl/keccak_absorb_stream.sv
// keccak_absorb_stream: absorb front-end for a Keccak permutation core.
// It XORs a byte-keyed stream into a 1600-bit state up to the rate boundary and
// carries beat bytes that straddle the boundary into the next rate block.
// On the last beat it applies the domain suffix and the 0x80 pad, then requests
// the final permutation.
// Optional build macro KECCAK_ABSORB_MSG_CNT_EN adds msg_bytes_o, a saturating
// count of the message bytes accepted since start_i.
// Stream handshake: a beat transfers on a rising clk edge where s_tvalid_i and
// s_tready_o are both high. s_tready_o depends only on registered state.
module keccak_absorb_stream #(
    parameter int DWIDTH    = 256,
    parameter int LANE_SIZE = 64,
    parameter int KEEP_W    = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [7:0]        rate_i,
    input  logic [7:0]        suffix_i,
    input  logic [DWIDTH-1:0] s_tdata_i,
    input  logic [KEEP_W-1:0] s_tkeep_i,
    input  logic              s_tvalid_i,
    input  logic              s_tlast_i,
    output logic              s_tready_o,
    output logic              perm_start_o,
    input  logic              perm_done_i,
    input  logic [1599:0]     perm_state_i,
    output logic [1599:0]     state_o,
    output logic [7:0]        bytes_absorbed_o,
    output logic              done_o
`ifdef KECCAK_ABSORB_MSG_CNT_EN
    ,
    output logic [63:0]       msg_bytes_o
`endif
);

    localparam int LB = LANE_SIZE / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_ABSORB, S_PERM_WAIT, S_PAD, S_FINAL_WAIT, S_DONE
    } state_e;

    state_e              state_q;
    logic [7:0]          rate_q, suffix_q, ba_q;
    logic [1599:0]       st_q;
    logic [DWIDTH-1:0]   carry_data_q;
    logic [KEEP_W-1:0]   carry_keep_q;
    logic                last_q, perm_start_q, done_q;

    logic                hs;
    logic [7:0]          beat_cnt, room, take, ba_d, carry_cnt, rate_m1;
    logic [DWIDTH-1:0]   beat_clean, beat_take, beat_rest;
    logic [KEEP_W-1:0]   keep_rest;
    logic [1599:0]       lin, xor_st;

    function automatic logic [7:0] popcnt(input logic [KEEP_W-1:0] k);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < KEEP_W; i++) c = c + {7'b0, k[i]};
        return c;
    endfunction

    // Linear rate-byte order -> [x][y] lane order (lane slot 5*x+y, x = idx%5, y = idx/5).
    function automatic logic [1599:0] lane_map(input logic [1599:0] l);
        logic [1599:0] m;
        int lane, pos;
        m = '0;
        for (int b = 0; b < 200; b++) begin
            lane = b / LB;
            pos  = 5 * (lane % 5) + lane / 5;
            m[LANE_SIZE*pos + 8*(b % LB) +: 8] = l[8*b +: 8];
        end
        return m;
    endfunction

    assign s_tready_o       = (state_q == S_ABSORB) && (carry_keep_q == '0);
    assign hs               = s_tvalid_i && s_tready_o;
    assign perm_start_o     = perm_start_q;
    assign done_o           = done_q;
    assign state_o          = st_q;
    assign bytes_absorbed_o = ba_q;

    // Byte accounting for the incoming beat and the XOR pattern for this cycle.
    always_comb begin
        beat_cnt  = popcnt(s_tkeep_i);
        carry_cnt = popcnt(carry_keep_q);
        room      = rate_q - ba_q;
        take      = (beat_cnt < room) ? beat_cnt : room;
        ba_d      = ba_q + take;
        rate_m1   = rate_q - 8'd1;
        beat_clean = '0;
        beat_take  = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            beat_clean[8*i +: 8] = s_tkeep_i[i] ? s_tdata_i[8*i +: 8] : 8'h00;
            beat_take[8*i +: 8]  = (8'(i) < take) ? beat_clean[8*i +: 8] : 8'h00;
        end
        beat_rest = beat_clean >> {take, 3'b000};
        keep_rest = s_tkeep_i >> take;
        case (state_q)
            S_ABSORB:    lin = {{(1600-DWIDTH){1'b0}}, beat_take} << {ba_q, 3'b000};
            S_PERM_WAIT: lin = {{(1600-DWIDTH){1'b0}}, carry_data_q};
            S_PAD:       lin = ({1592'b0, suffix_q} << {ba_q, 3'b000})
                             ^ ({1592'b0, 8'h80} << {rate_m1, 3'b000});
            default:     lin = '0;
        endcase
        xor_st = lane_map(lin);
    end

    // Main FSM: state register, carry buffer and registered handshake/permutation outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rate_q       <= '0;
            suffix_q     <= '0;
            ba_q         <= '0;
            st_q         <= '0;
            carry_data_q <= '0;
            carry_keep_q <= '0;
            last_q       <= 1'b0;
            perm_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            perm_start_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        st_q         <= '0;
                        rate_q       <= rate_i;
                        suffix_q     <= suffix_i;
                        ba_q         <= '0;
                        done_q       <= 1'b0;
                        carry_data_q <= '0;
                        carry_keep_q <= '0;
                        last_q       <= 1'b0;
                        state_q      <= S_ABSORB;
                    end
                end
                S_ABSORB: begin
                    if (hs) begin
                        st_q         <= st_q ^ xor_st;
                        ba_q         <= ba_d;
                        carry_data_q <= beat_rest;
                        carry_keep_q <= keep_rest;
                        last_q       <= s_tlast_i;
                        if (ba_d == rate_q) begin
                            perm_start_q <= 1'b1;
                            state_q      <= S_PERM_WAIT;
                        end else if (s_tlast_i) begin
                            state_q <= S_PAD;
                        end
                    end
                end
                S_PERM_WAIT: begin
                    if (perm_done_i) begin
                        // Carried bytes land at offset 0 of the fresh block.
                        st_q         <= perm_state_i ^ xor_st;
                        ba_q         <= carry_cnt;
                        carry_data_q <= '0;
                        carry_keep_q <= '0;
                        state_q      <= last_q ? S_PAD : S_ABSORB;
                    end
                end
                S_PAD: begin
                    st_q         <= st_q ^ xor_st;
                    perm_start_q <= 1'b1;
                    state_q      <= S_FINAL_WAIT;
                end
                S_FINAL_WAIT: begin
                    if (perm_done_i) begin
                        st_q    <= perm_state_i;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef KECCAK_ABSORB_MSG_CNT_EN
    logic [63:0] msg_cnt_q;
    logic [64:0] msg_sum;

    assign msg_sum     = {1'b0, msg_cnt_q} + {57'b0, beat_cnt};
    assign msg_bytes_o = msg_cnt_q;

    // Saturating count of accepted message bytes since the last start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_cnt_q <= '0;
        end else if (start_i && (state_q == S_IDLE || state_q == S_DONE)) begin
            msg_cnt_q <= '0;
        end else if (hs) begin
            msg_cnt_q <= msg_sum[64] ? '1 : msg_sum[63:0];
        end
    end
`endif

endmodule

// File: tb/tb_keccak_absorb_stream.sv
// Bench for keccak_absorb_stream (DWIDTH = 256). Random messages are padded by a
// byte-level sponge model; a responder plays the permutation core with random
// results, and every pre-permutation state is checked lane by lane.
module tb_keccak_absorb_stream;

    localparam int DW = 256;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [7:0]    rate_i, suffix_i;
    logic [DW-1:0] s_tdata_i;
    logic [KW-1:0] s_tkeep_i;
    logic          s_tvalid_i, s_tlast_i, s_tready_o;
    logic          perm_start_o, perm_done_i, done_o;
    logic [1599:0] perm_state_i, state_o;
    logic [7:0]    bytes_absorbed_o;
`ifdef KECCAK_ABSORB_MSG_CNT_EN
    logic [63:0]   msg_bytes_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] msg_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] ms[200];
    int cur_len, cur_rate, cur_nb;

    keccak_absorb_stream #(.DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .rate_i(rate_i),
        .suffix_i(suffix_i), .s_tdata_i(s_tdata_i), .s_tkeep_i(s_tkeep_i),
        .s_tvalid_i(s_tvalid_i), .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o),
        .perm_start_o(perm_start_o), .perm_done_i(perm_done_i),
        .perm_state_i(perm_state_i), .state_o(state_o),
        .bytes_absorbed_o(bytes_absorbed_o), .done_o(done_o)
`ifdef KECCAK_ABSORB_MSG_CNT_EN
        , .msg_bytes_o(msg_bytes_o)
`endif
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // lane (x,y) sits at slot 5*x+y; it holds rate bytes 8*(x+5*y) .. +7, little endian
    function automatic logic [1599:0] pack(input logic [7:0] b[200]);
        logic [1599:0] s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int k = 0; k < 8; k++)
                    s[64*(5*x+y) + 8*k +: 8] = b[8*(x+5*y) + k];
        return s;
    endfunction

    task automatic unpack_to_ms(input logic [1599:0] s);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int k = 0; k < 8; k++)
                    ms[8*(x+5*y) + k] = s[64*(5*x+y) + 8*k +: 8];
    endtask

    task automatic check_state(input string tag, input logic [1599:0] exp);
        for (int l = 0; l < 25; l++)
            check($sformatf("%s_lane%0d", tag, l), state_o[64*l +: 64], exp[64*l +: 64]);
    endtask

    task automatic drive_beats();
        int pos, cnt, nbeats, cyc;
        pos = 0;
        nbeats = (cur_len == 0) ? 1 : (cur_len + KW - 1) / KW;
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_tvalid_i = 1'b0;
                @(negedge clk);
            end
            cnt = (cur_len - pos < KW) ? cur_len - pos : KW;
            for (int w = 0; w < DW / 32; w++) s_tdata_i[32*w +: 32] = $urandom;
            s_tkeep_i = '0;
            for (int j = 0; j < cnt; j++) begin
                s_tdata_i[8*j +: 8] = msg_q[pos + j];
                s_tkeep_i[j] = 1'b1;
            end
            s_tlast_i  = (b == nbeats - 1);
            s_tvalid_i = 1'b1;
            cyc = 0;
            while (!s_tready_o && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 200) begin
                check("tready_timeout", 64'd1, 64'd0);
                s_tvalid_i = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            s_tvalid_i = 1'b0;
            pos += cnt;
        end
    endtask

    task automatic respond();
        int cyc, lat, delivered, after;
        logic [7:0]    e[200];
        logic [1599:0] r;
        for (int k = 0; k < cur_nb; k++) begin
            cyc = 0;
            while (!perm_start_o && cyc < 300) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 300) begin
                check("perm_start_timeout", 64'd0, 64'd1);
                return;
            end
            for (int i = 0; i < 200; i++)
                e[i] = ms[i] ^ ((i < cur_rate) ? exp_q[k*cur_rate + i] : 8'h00);
            check_state($sformatf("pre_perm%0d", k), pack(e));
            check("tready_in_perm", {63'b0, s_tready_o}, 64'd0);
            check("done_before_final", {63'b0, done_o}, 64'd0);
            if (k < cur_nb - 1)
                check("ba_at_fill", {56'b0, bytes_absorbed_o}, 64'(cur_rate));
            else
                check("ba_at_pad", {56'b0, bytes_absorbed_o}, 64'(cur_len - (cur_nb - 1) * cur_rate));
            @(negedge clk);
            check("perm_start_one_cycle", {63'b0, perm_start_o}, 64'd0);
            lat = $urandom_range(0, 3);
            repeat (lat) @(negedge clk);
            for (int w = 0; w < 50; w++) r[32*w +: 32] = $urandom;
            perm_state_i = r;
            perm_done_i  = 1'b1;
            @(negedge clk);
            perm_done_i = 1'b0;
            unpack_to_ms(r);
            if (k < cur_nb - 1) begin
                delivered = ((cur_rate * (k + 1) + KW - 1) / KW) * KW;
                if (delivered > cur_len) delivered = cur_len;
                check("ba_after_carry", {56'b0, bytes_absorbed_o}, 64'(delivered - cur_rate * (k + 1)));
            end else begin
                check("done_after_final", {63'b0, done_o}, 64'd1);
                check_state("final", r);
            end
        end
        after = 0;
        repeat (3) begin
            @(negedge clk);
            if (perm_start_o) after++;
        end
        check("no_extra_perm", 64'(after), 64'd0);
        check("done_held", {63'b0, done_o}, 64'd1);
    endtask

    task automatic run_msg(input int rate, input logic [7:0] sfx, input int len);
        cur_len  = len;
        cur_rate = rate;
        cur_nb   = len / rate + 1;
        msg_q.delete();
        exp_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
        // sponge padding: suffix at the end of the message, 0x80 in the last byte of the block
        for (int i = 0; i < cur_nb * rate; i++) exp_q.push_back((i < len) ? msg_q[i] : 8'h00);
        exp_q[len] = exp_q[len] ^ sfx;
        exp_q[cur_nb * rate - 1] = exp_q[cur_nb * rate - 1] ^ 8'h80;
        for (int i = 0; i < 200; i++) ms[i] = 8'h00;
        @(negedge clk);
        rate_i   = 8'(rate);
        suffix_i = sfx;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("ba_after_start", {56'b0, bytes_absorbed_o}, 64'd0);
        check("done_after_start", {63'b0, done_o}, 64'd0);
        fork
            drive_beats();
            respond();
        join
`ifdef KECCAK_ABSORB_MSG_CNT_EN
        check("msg_bytes", msg_bytes_o, 64'(len));
`endif
    endtask

    task automatic run_reset_test();
        int cyc;
        @(negedge clk);
        rate_i   = 8'd136;
        suffix_i = 8'h06;
        start_i  = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        s_tkeep_i  = '1;
        s_tlast_i  = 1'b0;
        s_tvalid_i = 1'b1;
        for (int w = 0; w < DW / 32; w++) s_tdata_i[32*w +: 32] = $urandom;
        cyc = 0;
        while (!perm_start_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        s_tvalid_i = 1'b0;
        check("rst_reached_perm_wait", {63'b0, perm_start_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_tready", {63'b0, s_tready_o}, 64'd0);
        check("rst_perm_start", {63'b0, perm_start_o}, 64'd0);
        check("rst_done", {63'b0, done_o}, 64'd0);
        check("rst_ba", {56'b0, bytes_absorbed_o}, 64'd0);
        check("rst_state_zero", {63'b0, |state_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 50; w++) perm_state_i[32*w +: 32] = $urandom;
        perm_done_i = 1'b1;
        @(negedge clk);
        perm_done_i = 1'b0;
        repeat (2) begin
            check("ign_state_zero", {63'b0, |state_o}, 64'd0);
            check("ign_tready", {63'b0, s_tready_o}, 64'd0);
            check("ign_done", {63'b0, done_o}, 64'd0);
            check("ign_perm_start", {63'b0, perm_start_o}, 64'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        int rates[5];
        rates = '{72, 104, 136, 144, 168};
        rst_n = 1'b0;
        start_i = 1'b0;
        rate_i = '0;
        suffix_i = '0;
        s_tdata_i = '0;
        s_tkeep_i = '0;
        s_tvalid_i = 1'b0;
        s_tlast_i = 1'b0;
        perm_done_i = 1'b0;
        perm_state_i = '0;
        #1;
        check("reset_tready", {63'b0, s_tready_o}, 64'd0);
        check("reset_perm_start", {63'b0, perm_start_o}, 64'd0);
        check("reset_done", {63'b0, done_o}, 64'd0);
        check("reset_ba", {56'b0, bytes_absorbed_o}, 64'd0);
        check("reset_state", {63'b0, |state_o}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_msg(136, 8'h06, 0);
        run_msg(136, 8'h06, 160);
        run_msg(72, 8'h06, 71);
        run_msg(136, 8'h1F, 136);
        run_msg(136, 8'h06, 69);
        for (int t = 0; t < 8; t++)
            run_msg(rates[$urandom_range(0, 4)], ($urandom_range(0, 1) == 1) ? 8'h1F : 8'h06,
                    int'($urandom_range(0, 360)));
        run_reset_test();
        run_msg(168, 8'h1F, 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_absorb_stream.md
Name: keccak_absorb_stream

Overview:
Sequential absorb front-end for the Keccak engine. It accepts a byte-keyed message stream of parametrised width and XORs it into an internally held 1600-bit state up to the rate boundary. Beats that straddle the boundary are buffered in a carry register, and the block requests a permutation each time the rate fills. On the last beat it applies the domain suffix and 0x80 pad, requests the final permutation and reports done. It sits between the input stream interface and the round/permutation core; squeeze logic reads state_o after done_o.

Parameters:
DWIDTH, 256, stream data width in bits; multiple of 64, range 64..512
LANE_SIZE, 64, Keccak lane width in bits; fixed at 64
KEEP_W, DWIDTH/8, derived: stream byte-keep width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
start_i  in  1  one-cycle pulse; clears state and samples rate_i/suffix_i; accepted only in IDLE or DONE
rate_i  in  8  rate in bytes: 72, 104, 136 or 144 (SHA3), 136 or 168 (SHAKE)
suffix_i  in  8  domain suffix byte: 0x06 SHA3, 0x1F SHAKE
s_tdata_i  in  DWIDTH  message beat; byte 0 at bits [7:0]
s_tkeep_i  in  KEEP_W  valid bytes; contiguous from bit 0; all ones unless s_tlast_i
s_tvalid_i  in  1  beat valid
s_tlast_i  in  1  last beat of message; keep may be 0 (empty tail)
s_tready_o  out  1  block can accept a beat this cycle
perm_start_o  out  1  one-cycle pulse: permute state_o
perm_done_i  in  1  one-cycle pulse: perm_state_i holds the result
perm_state_i  in  1600  permuted state, loaded on perm_done_i
state_o  out  1600  current state register, [x][y] lane order
bytes_absorbed_o  out  8  byte position within the current rate block
done_o  out  1  high from final perm_done_i until next start_i

Behaviour:
- Reset: FSM to IDLE. State, carry, bytes_absorbed_o, carry_keep cleared. s_tready_o, perm_start_o and done_o are 0.
- States: IDLE, ABSORB, PERM_WAIT, PAD, FINAL_WAIT, DONE.
- IDLE/DONE with start_i: state <= 0, latch rate/suffix, bytes_absorbed <= 0, done_o <= 0, go to ABSORB.
- ABSORB:
  - s_tready_o = 1 while carry is empty.
  - On handshake, absorb n = min(popcount(keep), rate - bytes_absorbed) bytes at offset bytes_absorbed. XOR is byte-granular and lane-spanning; lane index is byte_offset/8, mapped x = idx%5, y = idx/5.
  - bytes_absorbed += n.
  - Remaining bytes, shifted to bit 0, go to the carry register with carry_keep. The tlast flag is stored with them.
- Rate full (bytes_absorbed == rate) after a handshake: perm_start_o pulses the next cycle, go to PERM_WAIT, s_tready_o = 0.
- PERM_WAIT on perm_done_i:
  - Load perm_state_i and set bytes_absorbed = 0.
  - If carry is pending, absorb it in the same cycle (it is always < rate bytes) and clear it.
  - Then go to PAD if the stored tlast is set, else ABSORB.
- tlast handshake without fill: go to PAD.
- tlast beat that exactly fills the rate: permute first; PAD then runs with bytes_absorbed = 0.
- PAD (one cycle):
  - state byte[bytes_absorbed] ^= suffix.
  - state byte[rate-1] ^= 0x80. Both are applied when they coincide (e.g. 0x86).
  - perm_start_o pulses, go to FINAL_WAIT.
- FINAL_WAIT on perm_done_i: load state, go to DONE, done_o = 1.
- perm_start_o is never asserted while a permutation is outstanding. perm_done_i outside a WAIT state is ignored.
- start_i during ABSORB/WAIT states is ignored.
- Reset mid-operation discards everything; any in-flight permutation result is ignored.
- Throughput: one full beat per cycle, except one stall cycle plus permutation latency at each rate boundary.

Optional Feature:
KECCAK_ABSORB_MSG_CNT_EN: adds output msg_bytes_o [63:0], the total message bytes accepted since start_i. It is cleared on reset/start, increments by popcount(keep) on each handshake, and saturates at 2^64-1. Without the macro the port and counter are absent; all other behaviour is identical.

Test Plan:
- Empty SHA3-256 (rate 136, suffix 0x06), one beat, keep=0, tlast=1:
  - one perm_start_o
  - state_o before perm: byte0 = 0x06, byte135 = 0x80, all else 0
  - done_o after perm_done_i
- Straddle, DWIDTH=256, rate 136, five full beats (160 B, last tlast):
  - after beat 5, bytes_absorbed = 136 (pre-perm), perm_start_o pulses, s_tready_o = 0
  - on perm_done_i, 24 B carry lands at lanes 0..2 and bytes_absorbed = 24
  - PAD puts 0x06 at byte 24 and 0x80 at byte 135
- SHA3-512 (rate 72), 71 B message (2 full beats + 7 B tail):
  - byte71 = 0x06 ^ 0x80 = 0x86
  - exactly one perm before done
- SHAKE256 exact fill: rate 136, DWIDTH=64, 17 beats of 0x1234_5678_9ABC_DEF0, tlast on 17th:
  - perm, then PAD with byte0 = 0x1F and byte135 = 0x80
  - second perm, done
- rst_n low in PERM_WAIT, then perm_done_i pulse:
  - outputs at reset values
  - pulse ignored, FSM stays IDLE
- With KECCAK_ABSORB_MSG_CNT_EN, 3 beats of keep 0xFFFFFFFF, 0xFFFFFFFF, 0x0000001F: msg_bytes_o = 69.
